cpa_stage: RTL

Pipelined carry-propagate stage at the tail of the multiplier datapath. Consumes the redundant sum/carry vectors produced by the compressor array and resolves them into the final binary product over two registered half-width additions. Uses a valid/ready handshake on both sides and sustains one product per cycle under backpressure without loss or duplication.

---
 rtl/mult_pkg.sv | 12 +
 rtl/cpa_half.sv | 22 ++
 rtl/cpa_stage.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared multiplier datapath constants.
// Used by the compressor array and the final carry-propagate stage.
package mult_pkg;

    localparam int PROD_W = 16;

    typedef struct packed {
        logic v;
        logic c;
    } slot_flags_t;

endpackage

// File: rtl/cpa_half.sv
// H-bit ripple adder with carry-in and carry-out.
// Combinational; synthesis maps it to the fastest adder available.
module cpa_half #(
    parameter int H = 8
) (
    input  logic [H-1:0] a,
    input  logic [H-1:0] b,
    input  logic         cin,
    output logic [H-1:0] s,
    output logic         cout
);

    logic [H:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{H{1'b0}}, cin};
    end

    assign s    = full[H-1:0];
    assign cout = full[H];

endmodule

// File: rtl/cpa_stage.sv
// Two-slot pipelined carry-propagate adder resolving sum/carry vectors.
// Low half resolved in S1, high half plus mid carry resolved into S2.
module cpa_stage
    import mult_pkg::*;
#(
    parameter int W = PROD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_sum,
    input  logic [W-1:0] in_carry,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_p,
    output logic         out_ovf
);

    localparam int H = W / 2;

    logic         s1_v_q, s1_v_d;
    logic [H-1:0] lo_q, lo_d;
    logic         cmid_q, cmid_d;
    logic [H-1:0] sum_hi_q, sum_hi_d;
    logic [H-1:0] carry_hi_q, carry_hi_d;

    logic         s2_v_q, s2_v_d;
    logic [W-1:0] p_q, p_d;
    logic         ovf_q, ovf_d;

    logic         s2_adv;
    logic         s1_adv;
    logic         accept;

    logic [H-1:0] lo_s;
    logic         lo_c;
    logic [H-1:0] hi_s;
    logic         hi_c;

    cpa_half #(.H(H)) u_lo (
        .a    (in_sum[H-1:0]),
        .b    (in_carry[H-1:0]),
        .cin  (1'b0),
        .s    (lo_s),
        .cout (lo_c)
    );

    cpa_half #(.H(H)) u_hi (
        .a    (sum_hi_q),
        .b    (carry_hi_q),
        .cin  (cmid_q),
        .s    (hi_s),
        .cout (hi_c)
    );

    // Only out_ready reaches in_ready combinationally.
    always_comb begin
        s2_adv   = !s2_v_q || out_ready;
        s1_adv   = !s1_v_q || s2_adv;
        in_ready = s1_adv && !rst;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        s1_v_d     = s1_v_q;
        lo_d       = lo_q;
        cmid_d     = cmid_q;
        sum_hi_d   = sum_hi_q;
        carry_hi_d = carry_hi_q;
        s2_v_d     = s2_v_q;
        p_d        = p_q;
        ovf_d      = ovf_q;

        if (s1_adv) begin
            s1_v_d = accept;
            if (accept) begin
                lo_d       = lo_s;
                cmid_d     = lo_c;
                sum_hi_d   = in_sum[W-1:H];
                carry_hi_d = in_carry[W-1:H];
            end
        end

        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                p_d   = {hi_s, lo_q};
                ovf_d = hi_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            lo_q       <= '0;
            cmid_q     <= 1'b0;
            sum_hi_q   <= '0;
            carry_hi_q <= '0;
            s2_v_q     <= 1'b0;
            p_q        <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_v_q     <= s1_v_d;
            lo_q       <= lo_d;
            cmid_q     <= cmid_d;
            sum_hi_q   <= sum_hi_d;
            carry_hi_q <= carry_hi_d;
            s2_v_q     <= s2_v_d;
            p_q        <= p_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_p     = p_q;
    assign out_ovf   = ovf_q;

endmodule
